// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// Turns one-word read/write commands into AXI4-Lite handshakes and returns
// the result together with the cycle count from accept to B/R handshake.
// Every output is driven from a register, so no input reaches an output
// within the same cycle.
module axi4_lite_master #(
    parameter int         data_width = 32,
    parameter int         addr_width = 5,
    parameter int         strb_width = data_width / 8,
    parameter logic [2:0] prot_value = 3'b000,
    parameter int         cnt_width  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    input  logic [strb_width-1:0] cmd_wstrb,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [data_width-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [cnt_width-1:0]  rsp_cycles,
    // write address channel
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [addr_width-1:0] AWADDR,
    output logic [2:0]            AWPROT,
    // write data channel
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [data_width-1:0] WDATA,
    output logic [strb_width-1:0] WSTRB,
    // write response channel
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    // read address channel
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [addr_width-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    // read data channel
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [data_width-1:0] RDATA,
    input  logic [1:0]            RRESP
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    logic [2:0]           state;
    logic                 aw_done;
    logic                 w_done;
    logic [cnt_width-1:0] cnt;

    // Latency counter step that sticks at all-ones instead of wrapping.
    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign AWPROT = prot_value;
    assign ARPROT = prot_value;

    // Transaction sequencer: owns state, every handshake output and the response registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b00;
            rsp_cycles <= '0;
            AWVALID    <= 1'b0;
            AWADDR     <= '0;
            WVALID     <= 1'b0;
            WDATA      <= '0;
            WSTRB      <= '0;
            BREADY     <= 1'b0;
            ARVALID    <= 1'b0;
            ARADDR     <= '0;
            RREADY     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        AWADDR    <= cmd_addr;
                        ARADDR    <= cmd_addr;
                        WDATA     <= cmd_wdata;
                        WSTRB     <= cmd_wstrb;
                        if (cmd_write) begin
                            state   <= S_WRITE;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state   <= S_READ;
                            ARVALID <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    cnt <= sat_inc(cnt);
                    // AW and W retire independently, in either order or together
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || (AWVALID && AWREADY)) && (w_done || (WVALID && WREADY))) begin
                        state  <= S_WRESP;
                        BREADY <= 1'b1;
                    end
                end
                S_WRESP: begin
                    cnt <= sat_inc(cnt);
                    if (BVALID) begin
                        BREADY     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_write  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_resp   <= BRESP;
                        rsp_cycles <= sat_inc(cnt);
                        state      <= S_RSP;
                    end
                end
                S_READ: begin
                    cnt <= sat_inc(cnt);
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    cnt <= sat_inc(cnt);
                    if (RVALID) begin
                        RREADY     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_write  <= 1'b0;
                        rsp_rdata  <= RDATA;
                        rsp_resp   <= RRESP;
                        rsp_cycles <= sat_inc(cnt);
                        state      <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a stub AXI4-Lite slave with programmable
// per-channel delays, a transaction-level reference (memory image, expected
// response queue, latency formula) and a per-cycle compare process.
`define CHK(nm, a, e) chk(nm, 64'(a), 64'(e))

module tb_axi4_lite_master;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] rsp_cycles;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic [DW-1:0] WDATA, RDATA;
    logic [SW-1:0] WSTRB;
    logic [1:0]    BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(
        .data_width(DW), .addr_width(AW), .strb_width(SW),
        .prot_value(3'b000), .cnt_width(CW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] slv_mem [8];

    // slave configuration for the transaction in flight
    int       aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0] bresp_cfg, rresp_cfg;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < SW; i++)
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [CW-1:0] sat_cycles(input int raw);
        int top;
        top = (1 << CW) - 1;
        return (raw > top) ? CW'(top) : CW'(raw);
    endfunction

    // ---------------- stub slave (drives at posedge+2) ----------------
    logic          aw_go, w_go, b_go, ar_go, r_go;
    logic          aw_done_s, w_done_s, ar_done_s;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [SW-1:0] ws;

    initial begin : slave
        {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
        BRESP = 2'b00; RRESP = 2'b00; RDATA = '0;
        {aw_go, w_go, b_go, ar_go, r_go, aw_done_s, w_done_s, ar_done_s} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        wa = '0; ra = '0; wd = '0; ws = '0;
        forever begin
            @(posedge ACLK); #2;
            if (ARESET) begin
                {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
                BRESP = 2'b00; RRESP = 2'b00; RDATA = '0;
                {aw_go, w_go, b_go, ar_go, r_go, aw_done_s, w_done_s, ar_done_s} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
            end else begin
                if (aw_go) begin aw_done_s = 1'b1; aw_cnt = 0; end
                if (w_go)  begin w_done_s = 1'b1; w_cnt = 0; end
                if (b_go) begin
                    slv_mem[wa[4:2]] = merge(slv_mem[wa[4:2]], wd, ws);
                    aw_done_s = 1'b0; w_done_s = 1'b0; b_cnt = 0;
                end
                if (ar_go) begin ar_done_s = 1'b1; ar_cnt = 0; end
                if (r_go)  begin ar_done_s = 1'b0; r_cnt = 0; end

                AWREADY = AWVALID && !aw_done_s && (aw_cnt >= aw_dly);
                if (AWVALID && !aw_done_s) aw_cnt++;
                aw_go = AWVALID && AWREADY;
                if (aw_go) wa = AWADDR;

                WREADY = WVALID && !w_done_s && (w_cnt >= w_dly);
                if (WVALID && !w_done_s) w_cnt++;
                w_go = WVALID && WREADY;
                if (w_go) begin wd = WDATA; ws = WSTRB; end

                BVALID = aw_done_s && w_done_s && (b_cnt >= b_dly);
                BRESP  = BVALID ? bresp_cfg : 2'b00;
                if (aw_done_s && w_done_s) b_cnt++;
                b_go = BVALID && BREADY;

                ARREADY = ARVALID && !ar_done_s && (ar_cnt >= ar_dly);
                if (ARVALID && !ar_done_s) ar_cnt++;
                ar_go = ARVALID && ARREADY;
                if (ar_go) ra = ARADDR;

                RVALID = ar_done_s && (r_cnt >= r_dly);
                RDATA  = RVALID ? slv_mem[ra[4:2]] : '0;
                RRESP  = RVALID ? rresp_cfg : 2'b00;
                if (ar_done_s) r_cnt++;
                r_go = RVALID && RREADY;
            end
        end
    end

    // ---------------- per-cycle compare (posedge+1) ----------------
    logic          seen_rst = 1'b0;
    logic          busy = 1'b0;
    int            bcount = 0;
    logic          p_cmd_ready, p_rsp_valid, p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [SW-1:0] p_wstrb;

    initial begin : compare
        logic cmd_hs, rsp_hs;
        forever begin
            @(posedge ACLK); #1;
            if (ARESET) begin
                seen_rst = 1'b1;
                `CHK("rst_awvalid", AWVALID, 1'b0);
                `CHK("rst_wvalid", WVALID, 1'b0);
                `CHK("rst_bready", BREADY, 1'b0);
                `CHK("rst_arvalid", ARVALID, 1'b0);
                `CHK("rst_rready", RREADY, 1'b0);
                `CHK("rst_cmd_ready", cmd_ready, 1'b1);
                `CHK("rst_rsp_valid", rsp_valid, 1'b0);
                `CHK("rst_awaddr", AWADDR, 0);
                `CHK("rst_wdata", WDATA, 0);
                `CHK("rst_rsp_rdata", rsp_rdata, 0);
                `CHK("rst_rsp_cycles", rsp_cycles, 0);
                exp_q.delete();
                busy = 1'b0;
                bcount = 0;
            end else if (seen_rst) begin
                cmd_hs = p_cmd_ready && cmd_valid;
                rsp_hs = p_rsp_valid && rsp_ready;

                if (cmd_hs) begin
                    busy = 1'b1;
                    bcount = 0;
                    if (exp_q.size() == 0) `CHK("cmd_without_model", 1, 0);
                    else if (exp_q[0].wr) begin
                        `CHK("aw_rise", AWVALID, 1'b1);
                        `CHK("w_rise", WVALID, 1'b1);
                        `CHK("ar_quiet", ARVALID, 1'b0);
                    end else begin
                        `CHK("ar_rise", ARVALID, 1'b1);
                        `CHK("aw_quiet", AWVALID, 1'b0);
                        `CHK("w_quiet", WVALID, 1'b0);
                    end
                end

                // a VALID holds with stable payload until its handshake, then drops
                if (p_awvalid) begin
                    if (AWREADY) `CHK("aw_drop", AWVALID, 1'b0);
                    else begin
                        `CHK("aw_hold", AWVALID, 1'b1);
                        `CHK("awaddr_stable", AWADDR, p_awaddr);
                    end
                end
                if (p_wvalid) begin
                    if (WREADY) `CHK("w_drop", WVALID, 1'b0);
                    else begin
                        `CHK("w_hold", WVALID, 1'b1);
                        `CHK("wdata_stable", WDATA, p_wdata);
                        `CHK("wstrb_stable", WSTRB, p_wstrb);
                    end
                end
                if (p_arvalid) begin
                    if (ARREADY) `CHK("ar_drop", ARVALID, 1'b0);
                    else begin
                        `CHK("ar_hold", ARVALID, 1'b1);
                        `CHK("araddr_stable", ARADDR, p_araddr);
                    end
                end
                if (exp_q.size() > 0) begin
                    if (AWVALID) `CHK("awaddr", AWADDR, exp_q[0].addr);
                    if (WVALID) begin
                        `CHK("wdata", WDATA, exp_q[0].wdata);
                        `CHK("wstrb", WSTRB, exp_q[0].wstrb);
                    end
                    if (ARVALID) `CHK("araddr", ARADDR, exp_q[0].addr);
                end
                if (AWVALID) `CHK("awprot", AWPROT, 3'b000);
                if (ARVALID) `CHK("arprot", ARPROT, 3'b000);

                if (p_bready && BVALID) begin
                    bcount++;
                    `CHK("rsp_after_b", rsp_valid, 1'b1);
                end
                if (p_rready && RVALID) `CHK("rsp_after_r", rsp_valid, 1'b1);

                if (rsp_hs) begin
                    if (exp_q.size() > 0) begin
                        if (exp_q[0].wr) `CHK("b_handshakes", bcount, 1);
                        void'(exp_q.pop_front());
                    end
                    busy = 1'b0;
                    `CHK("rsp_drop", rsp_valid, 1'b0);
                end else if (rsp_valid) begin
                    if (exp_q.size() == 0) `CHK("rsp_spurious", 1, 0);
                    else begin
                        `CHK("rsp_write", rsp_write, exp_q[0].wr);
                        n_chk++;
                        if (rsp_rdata !== exp_q[0].rdata) begin
                            n_fail++;
                            $display("FAIL rsp_rdata: got 0x%0h, expected 0x%0h (t=%0t)",
                                     rsp_rdata, exp_q[0].rdata, $time);
                        end
                        `CHK("rsp_resp", rsp_resp, exp_q[0].resp);
                        n_chk++;
                        if (rsp_cycles !== exp_q[0].cyc) begin
                            n_fail++;
                            $display("FAIL rsp_cycles: got %0d, expected %0d (t=%0t)",
                                     rsp_cycles, exp_q[0].cyc, $time);
                        end
                    end
                end
                n_chk++;
                if (cmd_ready !== !busy) begin
                    n_fail++;
                    $display("FAIL cmd_ready: got %0b, expected %0b (t=%0t)", cmd_ready, !busy, $time);
                end
            end
            p_cmd_ready = cmd_ready; p_rsp_valid = rsp_valid;
            p_awvalid = AWVALID; p_wvalid = WVALID; p_arvalid = ARVALID;
            p_bready = BREADY; p_rready = RREADY;
            p_awaddr = AWADDR; p_araddr = ARADDR; p_wdata = WDATA; p_wstrb = WSTRB;
        end
    end

    // ---------------- stimulus (drives at negedge) ----------------
    function automatic exp_t make_exp(input logic wr, input logic [AW-1:0] addr,
                                      input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                      input int d0, input int d1, input int d2, input logic [1:0] resp);
        exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = data; e.wstrb = strb; e.resp = resp;
        if (wr) begin
            e.rdata = '0;
            e.cyc   = sat_cycles(2 + ((d0 > d1) ? d0 : d1) + d2);
        end else begin
            e.rdata = ref_mem[addr[4:2]];
            e.cyc   = sat_cycles(2 + d0 + d1);
        end
        return e;
    endfunction

    task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb, input int d0, input int d1, input int d2,
                       input logic [1:0] resp, input int hold,
                       output logic [DW-1:0] o_rdata, output logic [1:0] o_resp,
                       output logic [CW-1:0] o_cyc);
        int n;
        if (wr) begin
            aw_dly = d0; w_dly = d1; b_dly = d2; bresp_cfg = resp;
        end else begin
            ar_dly = d0; r_dly = d1; rresp_cfg = resp;
        end
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
        if (!cmd_ready) `CHK("cmd_ready_timeout", cmd_ready, 1'b1);
        exp_q.push_back(make_exp(wr, addr, data, strb, d0, d1, d2, resp));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
        if (!rsp_valid) `CHK("rsp_valid_timeout", rsp_valid, 1'b1);
        repeat (hold) @(negedge ACLK);
        o_rdata = rsp_rdata; o_resp = rsp_resp; o_cyc = rsp_cycles;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        if (wr) ref_mem[addr[4:2]] = merge(ref_mem[addr[4:2]], data, strb);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        logic [CW-1:0] cy;
        logic          wr;
        logic [AW-1:0] ad;
        int            d0, d1, d2;
        for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // write then read back
        txn(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, rd, rs, cy);
        n_chk++;
        if (rs !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_resp: got 0x%0h, expected 0x0", rs);
        end
        `CHK("wr_cycles_zero_wait", cy, 2);
        txn(1'b0, 5'h04, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, rd, rs, cy);
        n_chk++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_data: got 0x%0h, expected 0xDEADBEEF", rd);
        end
        `CHK("rd_cycles_zero_wait", cy, 2);

        // partial strobe
        txn(1'b1, 5'h08, 32'h11223344, 4'hF, 0, 0, 0, 2'b00, 0, rd, rs, cy);
        txn(1'b1, 5'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 2'b00, 0, rd, rs, cy);
        txn(1'b0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, rd, rs, cy);
        n_chk++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strobe_merge: got 0x%0h, expected 0x11BB33DD", rd);
        end

        // handshake ordering
        txn(1'b1, 5'h0C, 32'h0000_00C0, 4'hF, 3, 0, 0, 2'b00, 0, rd, rs, cy);
        `CHK("w_before_aw_cycles", cy, 5);
        txn(1'b1, 5'h10, 32'h0000_0010, 4'hF, 0, 3, 0, 2'b00, 0, rd, rs, cy);
        `CHK("aw_before_w_cycles", cy, 5);
        txn(1'b1, 5'h14, 32'h0000_0014, 4'hF, 2, 2, 0, 2'b00, 0, rd, rs, cy);
        `CHK("aw_w_together_cycles", cy, 4);
        txn(1'b1, 5'h18, 32'h0000_0018, 4'hF, 0, 1, 0, 2'b00, 0, rd, rs, cy);
        `CHK("w_one_late_cycles", cy, 3);

        // B backpressure with error response, response held off
        txn(1'b1, 5'h1C, 32'h5A5A_A5A5, 4'hF, 0, 0, 5, 2'b10, 4, rd, rs, cy);
        `CHK("slverr_resp", rs, 2'b10);
        `CHK("slverr_cycles", cy, 7);

        // counter saturation
        txn(1'b0, 5'h04, 32'h0, 4'h0, 0, 20, 0, 2'b00, 0, rd, rs, cy);
        `CHK("sat_cycles", cy, 15);
        `CHK("sat_rdata", rd, 32'hDEADBEEF);

        // reset in the middle of a write
        aw_dly = 10; w_dly = 10; b_dly = 0; bresp_cfg = 2'b00;
        exp_q.push_back(make_exp(1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 10, 10, 0, 2'b00));
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h10;
        cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        @(negedge ACLK);
        `CHK("awvalid_before_reset", AWVALID, 1'b1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        `CHK("mid_rst_awvalid", AWVALID, 1'b0);
        `CHK("mid_rst_wvalid", WVALID, 1'b0);
        `CHK("mid_rst_cmd_ready", cmd_ready, 1'b1);
        `CHK("mid_rst_rsp_valid", rsp_valid, 1'b0);
        txn(1'b0, 5'h04, 32'h0, 4'h0, 1, 1, 0, 2'b00, 0, rd, rs, cy);
        `CHK("post_rst_rdata", rd, 32'hDEADBEEF);
        `CHK("post_rst_cycles", cy, 4);
        txn(1'b0, 5'h10, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, rd, rs, cy);
        `CHK("abandoned_write_absent", rd, 32'h0000_0010);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            ad = AW'($urandom_range(0, 7) * 4);
            d0 = $urandom_range(0, 4);
            if (wr) begin
                d1 = $urandom_range(0, 4);
                d2 = $urandom_range(0, 6);
            end else begin
                d1 = ($urandom_range(0, 7) == 0) ? 18 : $urandom_range(0, 6);
                d2 = 0;
            end
            txn(wr, ad, $urandom, SW'($urandom_range(0, 15)), d0, d1, d2,
                2'($urandom_range(0, 3)), $urandom_range(0, 3), rd, rs, cy);
        end

        repeat (3) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
